// File: rtl/mor1kx_rf_writeback_espresso_pkg.sv
// Shared constants for the espresso RF write-back front end: producer indices.
package mor1kx_rf_writeback_espresso_pkg;

  localparam int NUM_SRC    = 3;
  localparam int SRC_ALU    = 0;
  localparam int SRC_LSU    = 1;
  localparam int SRC_MULDIV = 2;

endpackage

// File: rtl/mor1kx_rf_scoreboard.sv
// Pending-destination bitmap: one bit per GPR, set on issue and cleared on
// result transfer, plus three combinational lookup ports.
module mor1kx_rf_scoreboard #(
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int OPTION_RF_WORDS      = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            set_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] set_adr_i,
  input  logic                            clr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] clr_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] lk0_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] lk1_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] lk2_adr_i,
  output logic                            lk0_pend_o,
  output logic                            lk1_pend_o,
  output logic                            lk2_pend_o
);

  logic [OPTION_RF_WORDS-1:0] pend;
  logic [OPTION_RF_WORDS-1:0] pend_nxt;

  // Set is applied after clear so a fresh producer for the same register wins.
  always_comb begin
    pend_nxt = pend;
    if (clr_i)
      pend_nxt[clr_adr_i] = 1'b0;
    if (set_i)
      pend_nxt[set_adr_i] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pend <= '0;
    else
      pend <= pend_nxt;
  end

  assign lk0_pend_o = pend[lk0_adr_i];
  assign lk1_pend_o = pend[lk1_adr_i];
  assign lk2_pend_o = pend[lk2_adr_i];

endmodule

// File: rtl/mor1kx_rf_writeback_espresso.sv
// Espresso RF write-side front end: arbitrates ALU/LSU/MUL-DIV results onto the
// single RF write port and tracks pending destinations for decode hazards.
// Optional: MOR1KX_RF_WB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module mor1kx_rf_writeback_espresso
  import mor1kx_rf_writeback_espresso_pkg::*;
#(
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int OPTION_RF_WORDS      = 32,
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_SRC-1:0]                      src_valid_i,
  output logic [NUM_SRC-1:0]                      src_ready_o,
  input  logic [NUM_SRC*OPTION_RF_ADDR_WIDTH-1:0] src_adr_i,
  input  logic [NUM_SRC*OPTION_OPERAND_WIDTH-1:0] src_data_i,
  input  logic                                    issue_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]         issue_adr_i,
  output logic                                    issue_stall_o,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]         rfa_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]         rfb_adr_i,
  output logic                                    rfa_hazard_o,
  output logic                                    rfb_hazard_o,
  output logic                                    rf_we_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0]         rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]         result_o
);

  localparam int AW = OPTION_RF_ADDR_WIDTH;
  localparam int DW = OPTION_OPERAND_WIDTH;

  logic [NUM_SRC-1:0] grant;
  logic [1:0]         grant_idx;
  logic               xfer;
  logic [AW-1:0]      xfer_adr;
  logic [DW-1:0]      xfer_data;
  logic               pend_issue;
  logic               pend_a;
  logic               pend_b;
  logic               sb_set;

`ifdef MOR1KX_RF_WB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;

  always_comb begin
    int cand;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_SRC)
        cand = cand - NUM_SRC;
      if (!found && src_valid_i[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = 2'(cand);
      end
    end
    if (!rst_n)
      grant = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (xfer)
      rr_ptr <= (grant_idx == 2'(NUM_SRC - 1)) ? 2'd0 : grant_idx + 2'd1;
  end
`else
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (src_valid_i[SRC_ALU]) begin
      grant[SRC_ALU] = 1'b1;
      grant_idx      = 2'(SRC_ALU);
    end else if (src_valid_i[SRC_LSU]) begin
      grant[SRC_LSU] = 1'b1;
      grant_idx      = 2'(SRC_LSU);
    end else if (src_valid_i[SRC_MULDIV]) begin
      grant[SRC_MULDIV] = 1'b1;
      grant_idx         = 2'(SRC_MULDIV);
    end
    if (!rst_n)
      grant = '0;
  end
`endif

  assign src_ready_o = grant;
  assign xfer        = |grant;
  assign xfer_adr    = xfer ? src_adr_i[grant_idx*AW +: AW]  : '0;
  assign xfer_data   = xfer ? src_data_i[grant_idx*DW +: DW] : '0;

  // r0 completes its handshake but never reaches the RF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_o   <= 1'b0;
      rfd_adr_o <= '0;
      result_o  <= '0;
    end else begin
      rf_we_o   <= xfer && (xfer_adr != '0);
      rfd_adr_o <= xfer_adr;
      result_o  <= xfer_data;
    end
  end

  assign sb_set = issue_i && !issue_stall_o && (issue_adr_i != '0);

  mor1kx_rf_scoreboard #(
    .OPTION_RF_ADDR_WIDTH (OPTION_RF_ADDR_WIDTH),
    .OPTION_RF_WORDS      (OPTION_RF_WORDS)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (sb_set),
    .set_adr_i  (issue_adr_i),
    .clr_i      (xfer),
    .clr_adr_i  (xfer_adr),
    .lk0_adr_i  (issue_adr_i),
    .lk1_adr_i  (rfa_adr_i),
    .lk2_adr_i  (rfb_adr_i),
    .lk0_pend_o (pend_issue),
    .lk1_pend_o (pend_a),
    .lk2_pend_o (pend_b)
  );

  assign issue_stall_o = pend_issue;

  // The last term covers the RF's one-cycle write-to-read window.
  assign rfa_hazard_o = pend_a
                      | (xfer && (xfer_adr == rfa_adr_i) && (rfa_adr_i != '0))
                      | (rf_we_o && (rfd_adr_o == rfa_adr_i));
  assign rfb_hazard_o = pend_b
                      | (xfer && (xfer_adr == rfb_adr_i) && (rfb_adr_i != '0))
                      | (rf_we_o && (rfd_adr_o == rfb_adr_i));

endmodule
